// File: rtl/boot_pkg.sv
// Shared types and constants for the instruction-memory boot sequencer.
// State encoding, word width and byte stride used by imem_boot_ctrl.
package boot_pkg;

  localparam int WORD_W      = 32;
  localparam int BYTE_STRIDE = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    ERR
  } boot_state_t;

endpackage

// File: rtl/boot_checksum.sv
// Running modulo-2^32 sum of accepted boot words and final-word compare.
// Used by imem_boot_ctrl only when BOOT_CHECKSUM_EN is defined.
module boot_checksum
  import boot_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accum,
  input  logic [WORD_W-1:0] data,
  input  logic [WORD_W-1:0] expected,
  output logic              match
);

  logic [WORD_W-1:0] sum;

  // Accumulate each accepted word; restart on every new load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (accum) begin
      sum <= sum + data;
    end
  end

  // The final word is still in flight, so fold it in before comparing.
  assign match = ((sum + data) == expected);

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot sequencer: holds the core in reset, streams a program into imem,
// drains the pipeline, then releases the core. Option: BOOT_CHECKSUM_EN.
module imem_boot_ctrl
  import boot_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          HOLD_CYCLES = 8,
  localparam int         CW = $clog2(DEPTH_WORDS) + 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef BOOT_CHECKSUM_EN
  input  logic [WORD_W-1:0] expected_sum,
`endif
  input  logic              start,
  input  logic              s_valid,
  input  logic [WORD_W-1:0] s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              instr_write,
  output logic [WORD_W-1:0] write_inst,
  output logic [31:0]       write_addr,
  output logic              core_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CW-1:0]     word_count
);

  boot_state_t state;
  boot_state_t nextState;
  logic [7:0]  holdCnt;
  logic        hs;
  logic        atEnd;
  logic        startLoad;
  logic        sumOk;

  assign hs        = s_valid & s_ready;
  assign atEnd     = (word_count == CW'(DEPTH_WORDS - 1));
  assign startLoad = start & (state != LOAD) & (state != HOLD);

`ifdef BOOT_CHECKSUM_EN
  boot_checksum u_sum (
    .clk      (clk),
    .reset    (reset),
    .clear    (startLoad),
    .accum    (hs),
    .data     (s_data),
    .expected (expected_sum),
    .match    (sumOk)
  );
`else
  assign sumOk = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    nextState  = state;
    s_ready    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    core_reset = 1'b1;
    unique case (state)
      IDLE: begin
        if (start) nextState = LOAD;
      end
      LOAD: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (hs) begin
          if (s_last) begin
            nextState = sumOk ? HOLD : ERR;
          end else if (atEnd) begin
            nextState = ERR;
          end
        end
      end
      HOLD: begin
        busy = 1'b1;
        if (holdCnt == 8'd0) nextState = RUN;
      end
      RUN: begin
        done       = 1'b1;
        core_reset = 1'b0;
        if (start) nextState = LOAD;
      end
      ERR: begin
        error = 1'b1;
        if (start) nextState = LOAD;
      end
      default: nextState = IDLE;
    endcase
  end

  // Count accepted words; a new load starts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_count <= '0;
    end else if (startLoad) begin
      word_count <= '0;
    end else if (hs) begin
      word_count <= word_count + 1'b1;
    end
  end

  // Registered write port: one strobe per handshake, one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_write <= 1'b0;
      write_inst  <= '0;
      write_addr  <= '0;
    end else begin
      instr_write <= hs;
      if (hs) begin
        write_inst <= s_data;
        write_addr <= BASE_ADDR
                    + 32'(word_count) * 32'(BYTE_STRIDE);
      end
    end
  end

  // Drain timer: loaded on entry to HOLD, counts down to release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      holdCnt <= '0;
    end else if (state == LOAD && nextState == HOLD) begin
      holdCnt <= 8'(HOLD_CYCLES);
    end else if (state == HOLD && holdCnt != 8'd0) begin
      holdCnt <= holdCnt - 8'd1;
    end
  end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl (DEPTH_WORDS=4, HOLD_CYCLES=8).
// Build with BOOT_CHECKSUM_EN to also exercise the checksum option.
module tb_imem_boot_ctrl;

  localparam int          DEPTH = 4;
  localparam int          HOLD  = 8;
  localparam logic [31:0] BASE  = 32'h0;
  localparam int          CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset;
  logic          start;
  logic          s_valid;
  logic [31:0]   s_data;
  logic          s_last;
  logic          s_ready;
  logic          instr_write;
  logic [31:0]   write_inst;
  logic [31:0]   write_addr;
  logic          core_reset;
  logic          busy;
  logic          done;
  logic          error;
  logic [CW-1:0] word_count;
`ifdef BOOT_CHECKSUM_EN
  logic [31:0]   expected_sum;
  logic [31:0]   sumAcc;
  logic [31:0]   badSum;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         q[$];
  int          total;
  int          bad;
  int          cyc;
  logic [31:0] expAddr;

  imem_boot_ctrl #(
    .DEPTH_WORDS (DEPTH),
    .BASE_ADDR   (BASE),
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
`ifdef BOOT_CHECKSUM_EN
    .expected_sum (expected_sum),
`endif
    .start        (start),
    .s_valid      (s_valid),
    .s_data       (s_data),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .instr_write  (instr_write),
    .write_inst   (write_inst),
    .write_addr   (write_addr),
    .core_reset   (core_reset),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .word_count   (word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest queued handshake.
  always @(negedge clk) begin
    if (instr_write === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexp_wr", 32'(instr_write), 32'd0);
      end else begin
        wr_t e;
        e = q.pop_front();
        chk("wr_addr", write_addr, e.addr);
        chk("wr_data", write_inst, e.data);
        chk("wr_cyc", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic doStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    expAddr = BASE;
`ifdef BOOT_CHECKSUM_EN
    sumAcc = '0;
`endif
  endtask

  // One cycle of source activity; acc is the expected s_ready.
  task automatic beat(input logic v, input logic [31:0] d,
                      input logic l, input logic acc);
    s_valid = v;
    s_data  = d;
    s_last  = l;
`ifdef BOOT_CHECKSUM_EN
    if (l) expected_sum = sumAcc + d + badSum;
`endif
    @(negedge clk);
    if (v) chk("s_ready", 32'(s_ready), 32'(acc));
    if (v && acc) begin
      q.push_back('{addr: expAddr, data: d, cyc: cyc + 1});
      expAddr = expAddr + 32'd4;
`ifdef BOOT_CHECKSUM_EN
      sumAcc = sumAcc + d;
`endif
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // From just after the last handshake edge: release lands HOLD+1 later.
  task automatic expectRelease(input string nm);
    repeat (HOLD) @(posedge clk);
    #1;
    chk({nm, "_rst_hi"}, 32'(core_reset), 32'd1);
    @(posedge clk);
    #1;
    chk({nm, "_rst_lo"}, 32'(core_reset), 32'd0);
    chk({nm, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    expAddr = BASE;
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_last  = 1'b0;
`ifdef BOOT_CHECKSUM_EN
    expected_sum = '0;
    sumAcc       = '0;
    badSum       = '0;
`endif
    #3;
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_wc", 32'(word_count), 32'd0);
    chk("rst_wr", 32'(instr_write), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Normal load, valid held high.
    doStart();
    chk("n_busy", 32'(busy), 32'd1);
    beat(1'b1, 32'h00500113, 1'b0, 1'b1);
    beat(1'b1, 32'h00C00193, 1'b0, 1'b1);
    beat(1'b1, 32'hFF718393, 1'b0, 1'b1);
    beat(1'b1, 32'h0023E233, 1'b1, 1'b1);
    chk("n_hold_busy", 32'(busy), 32'd1);
    expectRelease("n");
    chk("n_wc", 32'(word_count), 32'd4);

    // Restart from RUN, then a stalling source.
    doStart();
    chk("rs_core_reset", 32'(core_reset), 32'd1);
    chk("rs_done", 32'(done), 32'd0);
    chk("rs_wc", 32'(word_count), 32'd0);
    beat(1'b1, 32'h11111111, 1'b0, 1'b1);
    beat(1'b0, 32'h22222222, 1'b0, 1'b1);
    beat(1'b0, 32'h33333333, 1'b0, 1'b1);
    beat(1'b1, 32'h44444444, 1'b1, 1'b1);
    expectRelease("st");
    chk("st_wc", 32'(word_count), 32'd2);

    // Overflow: fourth non-last word fills memory and aborts.
    doStart();
    beat(1'b1, 32'hA0000000, 1'b0, 1'b1);
    beat(1'b1, 32'hA0000001, 1'b0, 1'b1);
    beat(1'b1, 32'hA0000002, 1'b0, 1'b1);
    beat(1'b1, 32'hA0000003, 1'b0, 1'b1);
    chk("ov_error", 32'(error), 32'd1);
    chk("ov_busy", 32'(busy), 32'd0);
    chk("ov_core_reset", 32'(core_reset), 32'd1);
    chk("ov_wc", 32'(word_count), 32'd4);
    beat(1'b1, 32'hA0000004, 1'b1, 1'b0);
    chk("ov_error2", 32'(error), 32'd1);
    doStart();
    chk("ov_clr_error", 32'(error), 32'd0);
    chk("ov_clr_busy", 32'(busy), 32'd1);
    chk("ov_clr_wc", 32'(word_count), 32'd0);

    // Start alongside a handshake is ignored, then reset mid-load.
    beat(1'b1, 32'hB0000000, 1'b0, 1'b1);
    start = 1'b1;
    beat(1'b1, 32'hB0000001, 1'b0, 1'b1);
    start = 1'b0;
    chk("sh_wc", 32'(word_count), 32'd2);
    chk("sh_wr_pending", 32'(instr_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("ar_wr", 32'(instr_write), 32'd0);
    chk("ar_core_reset", 32'(core_reset), 32'd1);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_ready", 32'(s_ready), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_idle_busy", 32'(busy), 32'd0);
    chk("ar_idle_done", 32'(done), 32'd0);
    chk("ar_idle_error", 32'(error), 32'd0);

    // Fresh load after reset starts back at the base address.
    doStart();
    beat(1'b1, 32'hC0000000, 1'b0, 1'b1);
    beat(1'b1, 32'hC0000001, 1'b1, 1'b1);
    expectRelease("ra");

`ifdef BOOT_CHECKSUM_EN
    badSum = 32'd0;
    doStart();
    beat(1'b1, 32'd1, 1'b0, 1'b1);
    beat(1'b1, 32'd2, 1'b0, 1'b1);
    beat(1'b1, 32'd3, 1'b1, 1'b1);
    chk("cs_ok_sum", expected_sum, 32'd6);
    expectRelease("cs");
    badSum = 32'd1;
    doStart();
    beat(1'b1, 32'd1, 1'b0, 1'b1);
    beat(1'b1, 32'd2, 1'b0, 1'b1);
    beat(1'b1, 32'd3, 1'b1, 1'b1);
    chk("cs_bad_sum", expected_sum, 32'd7);
    chk("cs_error", 32'(error), 32'd1);
    chk("cs_wc", 32'(word_count), 32'd3);
    badSum = 32'd0;
`endif

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("q_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot sequencer for the pipelined RISC-V core. It holds the core in reset, streams a program from a word-wide valid/ready source into instruction memory through the core's instruction-write port, flushes the pipeline, and then releases the core. It sits between the bench or host loader and the core top, and drives the core's reset and instruction-write inputs.

## Interface
- `DEPTH_WORDS`, 64: instruction memory capacity in 32-bit words, with a minimum of 2.
- `BASE_ADDR`, 32'h0: byte address of the first loaded word.
- `HOLD_CYCLES`, 8: number of cycles the core reset stays asserted after the last write. The range is 1..255.
- `clk` in 1: the single clock; every register updates on its rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request to begin or restart a load.
- `s_valid` in 1: a program word is present on `s_data`.
- `s_data` in 32: the program word.
- `s_last` in 1: qualifies `s_data` as the final word.
- `s_ready` out 1: the block accepts a word this cycle.
- `instr_write` out 1: instruction-memory write strobe, asserted for one cycle per word.
- `write_inst` out 32: data for the instruction-memory write.
- `write_addr` out 32: byte address for the instruction-memory write.
- `core_reset` out 1: reset to the core, active-high.
- `busy` out 1: the block is in LOAD or HOLD.
- `done` out 1: the core is running a completely loaded program.
- `error` out 1: the load was aborted.
- `word_count` out `$clog2(DEPTH_WORDS)+1`: number of words accepted in the current load.

## Operation
- **States:** IDLE, LOAD, HOLD, RUN, ERR.
- **Reset values:** state is IDLE, `core_reset`=1 and every other output is 0.
- **IDLE:** `start` moves the state to LOAD, clears `word_count`, and clears `error`.
- **LOAD:**
  - `s_ready`=1.
  - A handshake (`s_valid`&`s_ready`) accepts the word. It is written to `write_addr = BASE_ADDR + 4*word_count`, and `word_count` increments.
  - A handshake with `s_last`=1 moves the state to HOLD.
  - A handshake without `s_last` when `word_count == DEPTH_WORDS-1` still writes that word, then moves to ERR (overflow).
  - `start` is ignored while in LOAD.
- **HOLD:**
  - A counter loads `HOLD_CYCLES` on entry and decrements every cycle.
  - When it reaches 0 the state moves to RUN.
  - `core_reset` stays 1 throughout, so the pipeline drains fully.
- **RUN:**
  - `core_reset`=0 and `done`=1.
  - `start` moves the state to LOAD, and `core_reset` is re-asserted on the same edge.
- **ERR:** `core_reset`=1 and `error`=1. `start` moves the state to LOAD.
- **`core_reset`:** it is 0 only in RUN, and in every other state it is 1.
- **Address width:** addresses are computed in 32 bits and never wrap, because depth is bounded by `DEPTH_WORDS`.

## Timing
- **`s_ready`:** combinational from state; it equals (state==LOAD).
- **Write latency:** `instr_write`, `write_inst` and `write_addr` are registered. They present the word exactly 1 cycle after its handshake, with no gaps, so back-to-back handshakes produce back-to-back strobes. When no write is pending, `instr_write`=0 and the data and address hold their last values.
- **Release:** the final write strobe occurs in the first HOLD cycle. `core_reset` falls `HOLD_CYCLES`+1 cycles after the last handshake edge.
- **`start` with a handshake:** `start` in the same cycle as a LOAD handshake has no effect.
- **Asynchronous `reset` mid-load:** the state returns to IDLE immediately, `instr_write` drops to 0, and the partial load is abandoned. Memory contents are not cleared.

## Configuration
- **`BOOT_CHECKSUM_EN` defined:**
  - The block adds input `expected_sum` [31:0].
  - It keeps a 32-bit modulo-2^32 sum of the accepted words, cleared on entry to LOAD.
  - On the `s_last` handshake it compares (sum + `s_data`) with `expected_sum`. A mismatch sends the state to ERR instead of HOLD, and the final word is still written.
- **Undefined:** there is no `expected_sum` port and no sum logic, and `s_last` always goes to HOLD.

## Structure
- **Package `boot_pkg`:**
  - State enum `boot_state_t` (IDLE, LOAD, HOLD, RUN, ERR).
  - The word width constant (32).
  - The byte stride constant (4).
- **Sub-module `boot_checksum`:** an accumulate/compare unit, instantiated only under `BOOT_CHECKSUM_EN`. All other logic stays in one module.

## Test plan
- **Normal load:** reset, `start`, then 4 words (0x00500113, 0x00C00193, 0xFF718393, 0x0023E233 with `s_last`), with `s_valid` held high. Expect 4 consecutive strobes at addresses 0x0, 0x4, 0x8, 0xC, `core_reset` falling 9 cycles after the last handshake, and `done`=1, `word_count`=4.
- **Source stalls:** `s_valid` toggles 1,0,0,1. Expect strobes only 1 cycle after each handshake and addresses still contiguous.
- **Overflow:** with `DEPTH_WORDS`=4, send 5 words where `s_last` is on the 5th. Expect 4 writes and `error`=1 after the 4th. Then `start` gives `error`=0, `busy`=1, `word_count`=0.
- **Reset mid-load:** assert `reset` after 2 handshakes. Expect `instr_write`=0 and `core_reset`=1 asynchronously, and state IDLE.
- **Restart from RUN:** `start` while `done`=1. Expect `core_reset`=1 on the next edge, `done`=0, and writes restarting at `BASE_ADDR`.
- **Checksum (with `BOOT_CHECKSUM_EN`):**
  - Words 1, 2, 3 with `expected_sum`=6 must reach RUN.
  - With `expected_sum`=7 they must reach ERR after 3 writes.
